// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, default widths
// and the port identifiers used for round-robin bookkeeping.
package mem_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 1;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time is chosen.
module rr_arb2
  import mem_pkg::*;
(
  input  logic a_req_i,
  input  logic b_req_i,
  input  logic last_grant_i,
  output logic winner_o,
  output logic valid_o
);

  always_comb begin
    valid_o  = a_req_i | b_req_i;
    winner_o = PORT_A;
    if (a_req_i && b_req_i) begin
      winner_o = (last_grant_i == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req_i) begin
      winner_o = PORT_B;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises port A/B transactions onto the single-word memory interface,
// issuing the post-reset clear and returning read data with a done strobe.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_done,
  output logic              b_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_add,
  output logic              mem_rw,
  output logic              mem_clear,
  output logic [DATA_W-1:0] mem_i,
  input  logic [DATA_W-1:0] mem_s
);

  state_e              state_q;
  logic                last_q;
  logic                port_q;
  logic                a_gnt_q, b_gnt_q, a_done_q, b_done_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   mem_add_q;
  logic                mem_rw_q, mem_clear_q;
  logic [DATA_W-1:0]   mem_i_q;
  logic                arb_win, arb_valid;

  rr_arb2 u_arb (
    .a_req_i      (a_req),
    .b_req_i      (b_req),
    .last_grant_i (last_q),
    .winner_o     (arb_win),
    .valid_o      (arb_valid)
  );

  // mem_add/mem_i double as the transaction latch; mem_rw_q still holds the
  // sampled we while in ACCESS, so it selects whether rdata captures mem_s.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;
      last_q      <= PORT_B;
      port_q      <= PORT_A;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      rdata_q     <= '0;
      mem_add_q   <= '0;
      mem_rw_q    <= 1'b0;
      mem_clear_q <= 1'b0;
      mem_i_q     <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          mem_clear_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        ST_IDLE: begin
          mem_clear_q <= 1'b0;
          if (arb_valid) begin
            state_q <= ST_ACCESS;
            port_q  <= arb_win;
            last_q  <= arb_win;
            if (arb_win == PORT_A) begin
              a_gnt_q   <= 1'b1;
              mem_add_q <= a_addr;
              mem_i_q   <= a_wdata;
              mem_rw_q  <= a_we;
            end else begin
              b_gnt_q   <= 1'b1;
              mem_add_q <= b_addr;
              mem_i_q   <= b_wdata;
              mem_rw_q  <= b_we;
            end
          end
        end
        ST_ACCESS: begin
          mem_rw_q <= 1'b0;
          if (!mem_rw_q) begin
            rdata_q <= mem_s;
          end
          a_done_q <= (port_q == PORT_A);
          b_done_q <= (port_q == PORT_B);
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          a_gnt_q  <= 1'b0;
          b_gnt_q  <= 1'b0;
          a_done_q <= 1'b0;
          b_done_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_done    = a_done_q;
  assign b_done    = b_done_q;
  assign rdata     = rdata_q;
  assign mem_add   = mem_add_q;
  assign mem_rw    = mem_rw_q;
  assign mem_clear = mem_clear_q;
  assign mem_i     = mem_i_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 2x8 memory attached.
module tb_mem_port_arbiter;

  logic       clk;
  logic       clear;
  logic       a_req, a_we, b_req, b_we;
  logic [0:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, b_gnt, a_done, b_done;
  logic [7:0] rdata;
  logic [0:0] mem_add;
  logic       mem_rw, mem_clear;
  logic [7:0] mem_i, mem_s;

  logic [7:0] mem [2];

  int n_chk  = 0;
  int n_pass = 0;

  mem_port_arbiter #(.DATA_W(8), .ADDR_W(1), .INIT_CLEAR(1)) dut (
    .clk(clk), .clear(clear),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done),
    .rdata(rdata), .mem_add(mem_add), .mem_rw(mem_rw), .mem_clear(mem_clear),
    .mem_i(mem_i), .mem_s(mem_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_s = mem[mem_add];
  always @(posedge clk) begin
    if (mem_clear) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
    end else if (mem_rw) begin
      mem[mem_add] <= mem_i;
    end
  end

  typedef struct {
    logic       clr;
    logic       a_req, a_we;
    logic [0:0] a_addr;
    logic [7:0] a_wdata;
    logic       b_req, b_we;
    logic [0:0] b_addr;
    logic [7:0] b_wdata;
    logic [22:0] exp;
  } vec_t;

  vec_t vt [18];

  function automatic logic [22:0] eo(input logic ag, bg, ad, bd, rw, mc,
                                     input logic [0:0] add, input logic [7:0] mi, rd);
    return {ag, bg, ad, bd, rw, mc, add, mi, rd};
  endfunction

  function automatic vec_t mkv(input logic clr, ar, aw, input logic [0:0] aa, input logic [7:0] ad,
                               input logic br, bw, input logic [0:0] ba, input logic [7:0] bd,
                               input logic [22:0] e);
    vec_t v;
    v.clr = clr; v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd; v.exp = e;
    return v;
  endfunction

  function automatic logic [22:0] outs();
    return {a_gnt, b_gnt, a_done, b_done, mem_rw, mem_clear, mem_add, mem_i, rdata};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] ord [4];
  int         nd, clr_cnt;
  logic       both_gnt, gnt_in_init, hit;

  initial begin
    // outputs packed as {a_gnt,b_gnt,a_done,b_done,mem_rw,mem_clear,mem_add,mem_i,rdata}
    vt[0]  = mkv(0, 0,0,0,8'h00, 0,0,0,8'h00, eo(0,0,0,0,0,0,0,8'h00,8'h00));
    vt[1]  = mkv(1, 1,1,1,8'h25, 0,0,0,8'h00, eo(0,0,0,0,0,1,0,8'h00,8'h00));
    vt[2]  = mkv(1, 1,1,1,8'h25, 0,0,0,8'h00, eo(1,0,0,0,1,0,1,8'h25,8'h00));
    vt[3]  = mkv(1, 1,1,1,8'h25, 0,0,0,8'h00, eo(1,0,1,0,0,0,1,8'h25,8'h00));
    vt[4]  = mkv(1, 0,0,0,8'h00, 1,0,1,8'hFF, eo(0,0,0,0,0,0,1,8'h25,8'h00));
    vt[5]  = mkv(1, 0,0,0,8'h00, 1,0,1,8'hFF, eo(0,1,0,0,0,0,1,8'hFF,8'h00));
    vt[6]  = mkv(1, 0,0,0,8'h00, 1,0,1,8'hFF, eo(0,1,0,1,0,0,1,8'hFF,8'h25));
    vt[7]  = mkv(1, 0,0,0,8'h00, 0,0,0,8'h00, eo(0,0,0,0,0,0,1,8'hFF,8'h25));
    vt[8]  = mkv(1, 1,1,0,8'h07, 0,0,0,8'h00, eo(1,0,0,0,1,0,0,8'h07,8'h25));
    vt[9]  = mkv(1, 1,1,0,8'h07, 0,0,0,8'h00, eo(1,0,1,0,0,0,0,8'h07,8'h25));
    vt[10] = mkv(1, 1,0,0,8'h00, 0,0,0,8'h00, eo(0,0,0,0,0,0,0,8'h07,8'h25));
    vt[11] = mkv(1, 1,0,0,8'h00, 0,0,0,8'h00, eo(1,0,0,0,0,0,0,8'h00,8'h25));
    vt[12] = mkv(1, 1,0,0,8'h00, 0,0,0,8'h00, eo(1,0,1,0,0,0,0,8'h00,8'h07));
    vt[13] = mkv(1, 1,0,1,8'h00, 0,0,0,8'h00, eo(0,0,0,0,0,0,0,8'h00,8'h07));
    vt[14] = mkv(1, 1,0,1,8'h00, 0,0,0,8'h00, eo(1,0,0,0,0,0,1,8'h00,8'h07));
    vt[15] = mkv(1, 1,0,1,8'h00, 0,0,0,8'h00, eo(1,0,1,0,0,0,1,8'h00,8'h25));
    vt[16] = mkv(1, 0,0,0,8'h00, 0,0,0,8'h00, eo(0,0,0,0,0,0,1,8'h00,8'h25));
    vt[17] = mkv(1, 0,0,0,8'h00, 0,0,0,8'h00, eo(0,0,0,0,0,0,1,8'h00,8'h25));

    clear = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    #2 clear = 1'b0;
    #1 chk("reset_outputs", {9'd0, outs()}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      clear = vt[i].clr;
      a_req = vt[i].a_req; a_we = vt[i].a_we; a_addr = vt[i].a_addr; a_wdata = vt[i].a_wdata;
      b_req = vt[i].b_req; b_we = vt[i].b_we; b_addr = vt[i].b_addr; b_wdata = vt[i].b_wdata;
      step();
      chk($sformatf("vec%0d", i), {9'd0, outs()}, {9'd0, vt[i].exp});
    end

    // Fairness: both ports requesting continuously from reset release.
    clear = 1'b0;
    a_req = 1; a_we = 0; a_addr = 1'b0; b_req = 1; b_we = 0; b_addr = 1'b1;
    repeat (2) step();
    clear = 1'b1;
    for (int k = 0; k < 4; k++) ord[k] = 2'd3;
    nd = 0; clr_cnt = 0; both_gnt = 0; gnt_in_init = 0;
    for (int c = 0; c < 60 && nd < 4; c++) begin
      step();
      if (a_gnt && b_gnt) both_gnt = 1;
      if (mem_clear) begin
        clr_cnt++;
        if (a_gnt || b_gnt) gnt_in_init = 1;
      end
      if (a_done) begin ord[nd] = 2'd0; nd++; end
      else if (b_done) begin ord[nd] = 2'd1; nd++; end
    end
    chk("t4_done_count", nd, 4);
    chk("t4_order0", ord[0], 0);
    chk("t4_order1", ord[1], 1);
    chk("t4_order2", ord[2], 0);
    chk("t4_order3", ord[3], 1);
    chk("t4_both_gnt", both_gnt, 0);
    chk("t4_clear_cycles", clr_cnt, 1);
    chk("t4_gnt_in_init", gnt_in_init, 0);
    a_req = 0; b_req = 0;
    repeat (3) step();

    // Reset caught mid-ACCESS of a B write.
    b_req = 1; b_we = 1; b_addr = 1'b0; b_wdata = 8'h5A;
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      step();
      if (b_gnt && mem_rw) hit = 1;
    end
    chk("t6_access", {21'd0, b_gnt, mem_rw, mem_add, mem_i}, {21'd0, 1'b1, 1'b1, 1'b0, 8'h5A});
    #1 clear = 1'b0;
    #1 chk("t6_async_reset", {9'd0, outs()}, 32'd0);
    step();
    chk("t6_no_done", {9'd0, outs()}, 32'd0);
    a_req = 1; a_we = 0; a_addr = 1'b0; a_wdata = 8'h00;
    clear = 1'b1;
    step();
    chk("t6_init_clear", {9'd0, outs()}, {9'd0, eo(0,0,0,0,0,1,0,8'h00,8'h00)});
    step();
    chk("t6_a_wins", {9'd0, outs()}, {9'd0, eo(1,0,0,0,0,0,0,8'h00,8'h00)});
    step();
    chk("t6_a_done", {9'd0, outs()}, {9'd0, eo(1,0,1,0,0,0,0,8'h00,8'h00)});
    a_req = 0; b_req = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
